// File: rtl/lsu_rmw.sv
// Load/store unit with read-modify-write sub-word stores, bus byte-lane swap and bus timeout.
// Optional atomics are built when LSU_AMO_EN is defined.
module lsu_rmw #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic              req_amo,
  input  logic [3:0]        req_amoop,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_err,
  output logic [ADDR_W-1:0] a,
  output logic [DATA_W-1:0] d,
  output logic              we,
  output logic              rd,
  input  logic [DATA_W-1:0] spo,
  input  logic              ready
);

  localparam int unsigned NB      = DATA_W / 8;
  localparam int unsigned OFF_W   = $clog2(NB);
  localparam int unsigned CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int unsigned TO_LAST = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;
  localparam logic [1:0]  ERR_OK  = 2'd0;
  localparam logic [1:0]  ERR_MIS = 2'd1;
  localparam logic [1:0]  ERR_TO  = 2'd2;
  localparam logic [1:0]  ERR_ILL = 2'd3;

  typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, MERGE, WR_ISSUE, WR_WAIT, RESP} state_t;

  state_t             r_state;
  logic               r_rd, r_we, r_rsp_valid;
  logic [ADDR_W-1:0]  r_a;
  logic [DATA_W-1:0]  r_d, r_rsp_rdata, r_wdata, r_old;
  logic [1:0]         r_rsp_err, r_sz;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_is_st, r_uns;
  logic [OFF_W-1:0]   r_off;

  // Byte at offset k travels on bits [DATA_W-1-8k -: 8] of the bus.
  function automatic logic [DATA_W-1:0] f_bswap(input logic [DATA_W-1:0] w);
    logic [DATA_W-1:0] o;
    o = '0;
    for (int k = 0; k < NB; k++) o[DATA_W-1-8*k -: 8] = w[8*k +: 8];
    return o;
  endfunction

  function automatic int unsigned f_shamt(input logic [1:0] sz);
    return DATA_W - (8 << sz);
  endfunction

  function automatic logic [DATA_W-1:0] f_extract(input logic [DATA_W-1:0] w,
      input logic [OFF_W-1:0] off, input logic [1:0] sz, input logic uns);
    logic [DATA_W-1:0]        s;
    logic signed [DATA_W-1:0] t;
    int unsigned              sh;
    sh = f_shamt(sz);
    s  = (w >> {off, 3'b000}) << sh;
    t  = s;
    t  = t >>> sh;
    if (uns) return s >> sh;
    return t;
  endfunction

  function automatic logic [DATA_W-1:0] f_mask(input logic [OFF_W-1:0] off, input logic [1:0] sz);
    logic [DATA_W-1:0] m;
    m = '1;
    m = m >> f_shamt(sz);
    return m << {off, 3'b000};
  endfunction

  logic [OFF_W-1:0]  w_size_m;
  logic              w_misal, w_full, w_sz_ill, w_illegal, w_to_hit;
  logic [ADDR_W-1:0] w_addr_al;
  logic [DATA_W-1:0] w_spo_le, w_mask, w_new, w_merged, w_wr_rdata;

  assign w_size_m  = OFF_W'((1 << req_size) - 1);
  assign w_misal   = |(req_addr[OFF_W-1:0] & w_size_m);
  assign w_full    = (req_size == 2'(OFF_W));
  assign w_sz_ill  = (req_size == 2'd3) && (DATA_W == 32);
  assign w_addr_al = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign w_spo_le  = f_bswap(spo);
  assign w_mask    = f_mask(r_off, r_sz);
  assign w_merged  = (r_old & ~w_mask) | ((w_new << {r_off, 3'b000}) & w_mask);
  assign w_to_hit  = (TIMEOUT != 0) && ((r_state == RD_WAIT) || (r_state == WR_WAIT))
                     && (r_cnt == CNT_W'(TO_LAST));

`ifdef LSU_AMO_EN
  logic              r_amo;
  logic [3:0]        r_amoop;
  logic [DATA_W-1:0] w_as, w_au, w_bs, w_bu, w_alu;

  assign w_illegal = w_sz_ill || (req_amo && ((req_size < 2'd2) || (req_amoop > 4'd8)));

  // AMO operands are the addressed lane of the old word and the right-aligned store operand.
  always_comb begin
    w_as  = f_extract(r_old, r_off, r_sz, 1'b0);
    w_au  = f_extract(r_old, r_off, r_sz, 1'b1);
    w_bs  = f_extract(r_wdata, '0, r_sz, 1'b0);
    w_bu  = f_extract(r_wdata, '0, r_sz, 1'b1);
    w_alu = w_bs;
    case (r_amoop)
      4'd1:    w_alu = w_as + w_bs;
      4'd2:    w_alu = w_as ^ w_bs;
      4'd3:    w_alu = w_as & w_bs;
      4'd4:    w_alu = w_as | w_bs;
      4'd5:    w_alu = ($signed(w_as) < $signed(w_bs)) ? w_as : w_bs;
      4'd6:    w_alu = ($signed(w_as) > $signed(w_bs)) ? w_as : w_bs;
      4'd7:    w_alu = (w_au < w_bu) ? w_au : w_bu;
      4'd8:    w_alu = (w_au > w_bu) ? w_au : w_bu;
      default: w_alu = w_bs;
    endcase
  end

  assign w_new      = r_amo ? w_alu : r_wdata;
  assign w_wr_rdata = r_amo ? f_extract(r_old, r_off, r_sz, 1'b0) : '0;
`else
  logic w_unused_amoop;
  assign w_unused_amoop = ^req_amoop;
  assign w_illegal      = w_sz_ill || req_amo;
  assign w_new          = r_wdata;
  assign w_wr_rdata     = '0;
`endif

  // Control FSM with registered bus strobes and response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;  r_rd <= 1'b0;  r_we <= 1'b0;  r_a <= '0;  r_d <= '0;
      r_rsp_valid <= 1'b0;  r_rsp_rdata <= '0;  r_rsp_err <= ERR_OK;  r_cnt <= '0;
      r_is_st <= 1'b0;  r_sz <= '0;  r_uns <= 1'b0;  r_off <= '0;  r_wdata <= '0;  r_old <= '0;
`ifdef LSU_AMO_EN
      r_amo <= 1'b0;  r_amoop <= '0;
`endif
    end else begin
      case (r_state)
        IDLE: if (req_valid) begin
          r_is_st <= req_we | req_amo;
          r_sz    <= req_size;
          r_uns   <= req_unsigned;
          r_off   <= req_addr[OFF_W-1:0];
          r_wdata <= req_wdata;
`ifdef LSU_AMO_EN
          r_amo   <= req_amo;
          r_amoop <= req_amoop;
`endif
          if (w_illegal || w_misal) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= '0;
            r_rsp_err   <= w_illegal ? ERR_ILL : ERR_MIS;
            r_state     <= RESP;
          end else begin
            r_a <= w_addr_al;
            if (req_we && !req_amo && w_full) begin
              r_we    <= 1'b1;
              r_d     <= f_bswap(req_wdata);
              r_state <= WR_ISSUE;
            end else begin
              r_rd    <= 1'b1;
              r_state <= RD_ISSUE;
            end
          end
        end
        RD_ISSUE, RD_WAIT: begin
          r_rd  <= 1'b0;
          r_cnt <= (r_state == RD_ISSUE) ? '0 : r_cnt + CNT_W'(1);
          if (ready) begin
            r_old <= w_spo_le;
            if (r_is_st) r_state <= MERGE;
            else begin
              r_rsp_valid <= 1'b1;
              r_rsp_rdata <= f_extract(w_spo_le, r_off, r_sz, r_uns);
              r_rsp_err   <= ERR_OK;
              r_state     <= RESP;
            end
          end else if (w_to_hit) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= '0;
            r_rsp_err   <= ERR_TO;
            r_state     <= RESP;
          end else r_state <= RD_WAIT;
        end
        MERGE: begin
          r_we    <= 1'b1;
          r_d     <= f_bswap(w_merged);
          r_state <= WR_ISSUE;
        end
        WR_ISSUE, WR_WAIT: begin
          r_we  <= 1'b0;
          r_cnt <= (r_state == WR_ISSUE) ? '0 : r_cnt + CNT_W'(1);
          if (ready || w_to_hit) begin
            r_rsp_valid <= 1'b1;
            r_rsp_rdata <= ready ? w_wr_rdata : '0;
            r_rsp_err   <= ready ? ERR_OK : ERR_TO;
            r_state     <= RESP;
          end else r_state <= WR_WAIT;
        end
        RESP: begin
          r_rsp_valid <= 1'b0;
          r_state     <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign req_ready = (r_state == IDLE);
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign a         = r_a;
  assign d         = r_d;
  assign we        = r_we;
  assign rd        = r_rd;

endmodule

// File: tb/tb_lsu_rmw.sv
// Directed bench for lsu_rmw (DATA_W=32, TIMEOUT=8) with a byte-swapped bus memory model.
module tb_lsu_rmw;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, req_unsigned = 1'b0, req_amo = 1'b0;
  logic [1:0]  req_size = '0;
  logic [3:0]  req_amoop = '0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, rsp_valid, we, rd;
  logic [31:0] rsp_rdata, a, d;
  logic [1:0]  rsp_err;
  logic [31:0] spo = '0;
  logic        ready = 1'b0;

  lsu_rmw #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_amo(req_amo), .req_amoop(req_amoop), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .a(a), .d(d), .we(we), .rd(rd), .spo(spo), .ready(ready)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] bswap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  // Bus memory: little-endian words, byte-swapped on the wires.
  logic [31:0] mem [0:255];
  logic        active = 1'b0, is_wr = 1'b0, never = 1'b0, force_rdy = 1'b0;
  int          cyc = 0, ws = 0, rd_cnt = 0, we_cnt = 0, a_bad = 0;
  logic [31:0] a0 = '0;

  always @(negedge clk) begin
    if (rst) begin
      active = 1'b0;
      ready  = 1'b0;
    end else begin
      if (ready) active = 1'b0;
      if (rd || we) begin
        active = 1'b1; cyc = 0; is_wr = we; a0 = a;
        if (rd) rd_cnt++;
        if (we) we_cnt++;
      end else if (active) begin
        cyc++;
        if (a !== a0) a_bad++;
      end
      ready = (active && !never && cyc == ws) || force_rdy;
      if (ready && active) begin
        if (is_wr) mem[a[9:2]] = bswap(d);
        else spo = bswap(mem[a[9:2]]);
      end
    end
  end

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  sz;
    logic        uns;
    logic        amo;
    logic [3:0]  op;
    logic [31:0] addr, wdata, init;
    int          ws;
    logic        nev;
    int          lat;
    logic [31:0] rdata;
    logic [1:0]  err;
    logic [31:0] mem;
    int          nrd, nwe;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name, logic w, logic [1:0] sz, logic uns, logic amo,
      logic [3:0] op, logic [31:0] addr, logic [31:0] wdata, logic [31:0] init, int wst,
      logic nev, int lat, logic [31:0] rdata, logic [1:0] err, logic [31:0] m, int nrd, int nwe);
    vec_t v;
    v.name = name; v.we = w; v.sz = sz; v.uns = uns; v.amo = amo; v.op = op;
    v.addr = addr; v.wdata = wdata; v.init = init; v.ws = wst; v.nev = nev;
    v.lat = lat; v.rdata = rdata; v.err = err; v.mem = m; v.nrd = nrd; v.nwe = nwe;
    return v;
  endfunction

  task automatic run_vec(input vec_t t);
    int          lat;
    logic [31:0] got_rdata;
    logic [1:0]  got_err;
    #1;
    active = 1'b0; rd_cnt = 0; we_cnt = 0; a_bad = 0;
    ws = t.ws; never = t.nev;
    mem[t.addr[9:2]] = t.init;
    @(negedge clk);
    chk({t.name, " req_ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = t.we; req_size = t.sz; req_unsigned = t.uns;
    req_amo = t.amo; req_amoop = t.op; req_addr = t.addr; req_wdata = t.wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = -1; got_rdata = '0; got_err = '0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = c; got_rdata = rsp_rdata; got_err = rsp_err;
        break;
      end
    end
    chk({t.name, " latency"}, 32'(lat), 32'(t.lat));
    chk({t.name, " err"}, 32'(got_err), 32'(t.err));
    if (!t.we || t.err != 2'd0) chk({t.name, " rdata"}, got_rdata, t.rdata);
    @(negedge clk);
    chk({t.name, " rsp pulse width"}, 32'(rsp_valid), 32'd0);
    chk({t.name, " rdata held"}, rsp_rdata, got_rdata);
    chk({t.name, " ready back"}, 32'(req_ready), 32'd1);
    chk({t.name, " memory"}, mem[t.addr[9:2]], t.mem);
    chk({t.name, " rd pulses"}, 32'(rd_cnt), 32'(t.nrd));
    chk({t.name, " we pulses"}, 32'(we_cnt), 32'(t.nwe));
    chk({t.name, " addr held"}, 32'(a_bad), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int stray;
    for (int i = 0; i < 256; i++) mem[i] = '0;

    vecs.push_back(mk("lw",      0, 2, 0, 0, 0, 32'h100, 0, 32'h12345678, 0, 0, 2, 32'h12345678, 0, 32'h12345678, 1, 0));
    vecs.push_back(mk("lb",      0, 0, 0, 0, 0, 32'h103, 0, 32'h80FF0011, 0, 0, 2, 32'hFFFFFF80, 0, 32'h80FF0011, 1, 0));
    vecs.push_back(mk("lbu",     0, 0, 1, 0, 0, 32'h103, 0, 32'h80FF0011, 0, 0, 2, 32'h00000080, 0, 32'h80FF0011, 1, 0));
    vecs.push_back(mk("lh",      0, 1, 0, 0, 0, 32'h102, 0, 32'h80FF0011, 0, 0, 2, 32'hFFFF80FF, 0, 32'h80FF0011, 1, 0));
    vecs.push_back(mk("lhu",     0, 1, 1, 0, 0, 32'h100, 0, 32'h80FF0011, 0, 0, 2, 32'h00000011, 0, 32'h80FF0011, 1, 0));
    vecs.push_back(mk("sb",      1, 0, 0, 0, 0, 32'h101, 32'hAB, 32'h44332211, 0, 0, 4, 0, 0, 32'h4433AB11, 1, 1));
    vecs.push_back(mk("sh_ws3",  1, 1, 0, 0, 0, 32'h102, 32'hBEEF, 32'h44332211, 3, 0, 10, 0, 0, 32'hBEEF2211, 1, 1));
    vecs.push_back(mk("sw",      1, 2, 0, 0, 0, 32'h104, 32'hCAFEBABE, 0, 0, 0, 2, 0, 0, 32'hCAFEBABE, 0, 1));
    vecs.push_back(mk("lw_mis",  0, 2, 0, 0, 0, 32'h102, 0, 32'h11111111, 0, 0, 1, 0, 1, 32'h11111111, 0, 0));
    vecs.push_back(mk("lh_mis",  0, 1, 0, 0, 0, 32'h101, 0, 32'h22222222, 0, 0, 1, 0, 1, 32'h22222222, 0, 0));
    vecs.push_back(mk("ld_ill",  0, 3, 0, 0, 0, 32'h100, 0, 32'h33333333, 0, 0, 1, 0, 3, 32'h33333333, 0, 0));
    vecs.push_back(mk("lw_to",   0, 2, 0, 0, 0, 32'h108, 0, 32'h00000055, 0, 1, 10, 0, 2, 32'h00000055, 1, 0));
    vecs.push_back(mk("lw_ws2",  0, 2, 0, 0, 0, 32'h10C, 0, 32'hA5A55A5A, 2, 0, 4, 32'hA5A55A5A, 0, 32'hA5A55A5A, 1, 0));
    vecs.push_back(mk("sb_hi",   1, 0, 0, 0, 0, 32'h100, 32'hFFFFFF5A, 32'h44332211, 0, 0, 4, 0, 0, 32'h4433225A, 1, 1));
    vecs.push_back(mk("sw_mis",  1, 2, 0, 0, 0, 32'h102, 32'hDEADBEEF, 32'h77777777, 0, 0, 1, 0, 1, 32'h77777777, 0, 0));
    vecs.push_back(mk("sh_to",   1, 1, 0, 0, 0, 32'h110, 32'hFFFF, 32'h00001234, 0, 1, 10, 0, 2, 32'h00001234, 1, 0));
`ifdef LSU_AMO_EN
    vecs.push_back(mk("amoadd",  0, 2, 0, 1, 1, 32'h200, 7, 5, 0, 0, 4, 5, 0, 12, 1, 1));
    vecs.push_back(mk("amomin",  0, 2, 0, 1, 5, 32'h204, 3, 32'hFFFFFFFE, 0, 0, 4, 32'hFFFFFFFE, 0, 32'hFFFFFFFE, 1, 1));
    vecs.push_back(mk("amominu", 0, 2, 0, 1, 7, 32'h208, 3, 32'hFFFFFFFE, 0, 0, 4, 32'hFFFFFFFE, 0, 3, 1, 1));
`else
    vecs.push_back(mk("amoadd",  0, 2, 0, 1, 1, 32'h200, 7, 5, 0, 0, 1, 0, 3, 5, 0, 0));
    vecs.push_back(mk("amomin",  0, 2, 0, 1, 5, 32'h204, 3, 32'hFFFFFFFE, 0, 0, 1, 0, 3, 32'hFFFFFFFE, 0, 0));
    vecs.push_back(mk("amominu", 0, 2, 0, 1, 7, 32'h208, 3, 32'hFFFFFFFE, 0, 0, 1, 0, 3, 32'hFFFFFFFE, 0, 0));
`endif

    // Reset values, during and after reset.
    repeat (2) @(negedge clk);
    chk("rst req_ready", 32'(req_ready), 32'd1);
    chk("rst strobes", {30'd0, rd, we}, 32'd0);
    chk("rst a", a, 32'd0);
    chk("rst d", d, 32'd0);
    chk("rst rsp", {29'd0, rsp_valid, rsp_err}, 32'd0);
    chk("rst rdata", rsp_rdata, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post-rst req_ready", 32'(req_ready), 32'd1);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Bus ready while idle must not produce activity.
    @(negedge clk);
    #1 force_rdy = 1'b1; rd_cnt = 0; we_cnt = 0;
    stray = 0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) stray++;
    end
    #1 force_rdy = 1'b0;
    chk("idle ready rsp", 32'(stray), 32'd0);
    chk("idle ready strobes", 32'(rd_cnt + we_cnt), 32'd0);

    // Reset during a read issue aborts with no response.
    @(negedge clk);
    ws = 20; never = 1'b1;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_amo = 1'b0; req_addr = 32'h100;
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk("abort rd issued", 32'(rd), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("abort rd dropped", 32'(rd), 32'd0);
    chk("abort a cleared", a, 32'd0);
    chk("abort req_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1 rst = 1'b0; never = 1'b0;
    stray = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid || rd || we) stray++;
    end
    chk("abort no response", 32'(stray), 32'd0);
    chk("abort idle", 32'(req_ready), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_rmw.md
# lsu_rmw

Parametrised load/store unit sitting between the multicycle core's execute stage and the system bus. It accepts one load, store or (optionally) atomic request at a time and performs sub-word stores by read-modify-write. It also converts between CPU little-endian data and the byte-swapped bus lanes, and reports misaligned, timed-out and illegal accesses instead of issuing them. It generalises the in-core byte/half handling to a configurable data width, adds a bus timeout, and adds optional AMO support.

## Interface
- DATA_W, 32, bus/register data width; 32 or 64.
- ADDR_W, 32, address width.
- TIMEOUT, 255, maximum wait cycles per bus beat before abort; 0 disables the timeout.
- clk  in  1  system clock.
- rst  in  1  reset; asynchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; a request is accepted on req_valid&req_ready at a rising edge.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  0 = B, 1 = H, 2 = W, 3 = D (D legal only when DATA_W=64).
- req_unsigned  in  1  zero-extend load result.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data/AMO operand, right-aligned.
- req_amo  in  1  atomic request (width W, or D when DATA_W=64).
- req_amoop  in  4  0 swap, 1 add, 2 xor, 3 and, 4 or, 5 min, 6 max, 7 minu, 8 maxu.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DATA_W  extended load data, or the old memory value for AMOs; 0 on error.
- rsp_err  out  2  0 ok, 1 misaligned, 2 timeout, 3 illegal.
- a  out  ADDR_W  bus address, aligned to DATA_W/8 bytes.
- d  out  DATA_W  bus write data, byte-swapped.
- we  out  1  bus write strobe.
- rd  out  1  bus read strobe.
- spo  in  DATA_W  bus read data, byte-swapped.
- ready  in  1  bus beat complete.

## Operation
- States: IDLE, RD_ISSUE, RD_WAIT, MERGE, WR_ISSUE, WR_WAIT, RESP.
- Request fields are latched at acceptance. Offset = addr[log2(DATA_W/8)-1:0].
- Check order:
  - Size illegal, or AMO requested without the macro → err=3.
  - Addr not aligned to its size → err=1.
  - An erroring request goes IDLE→RESP with no bus activity.
- Load path: IDLE→RD_ISSUE→(RD_WAIT)→RESP. The lane at the offset is extracted and sign- or zero-extended.
- Full-width store: IDLE→WR_ISSUE→(WR_WAIT)→RESP.
- Sub-word store: IDLE→RD_ISSUE→(RD_WAIT)→MERGE→WR_ISSUE→(WR_WAIT)→RESP. MERGE replaces only the addressed lanes of the captured word.
- AMO: same path as a sub-word store. MERGE computes op(old, wdata); min/max are signed or unsigned per op. rsp_rdata returns the old value.
- Bus lane mapping: the byte at offset k sits on bits [DATA_W-1-8k -: 8] of both d and spo.
- Bus rule:
  - rd/we are high for exactly the ISSUE cycle.
  - a (and d on writes) is held from ISSUE until ready is seen.
  - ready is sampled in ISSUE and WAIT. ready high in ISSUE skips WAIT.
  - spo is captured on the cycle ready is high.
- Timeout: a wait counter clears in ISSUE and increments in each WAIT cycle. When it reaches TIMEOUT without ready, the unit goes to RESP with err=2. For an RMW, the write is not issued.

## Timing
- Reset values:
  - State IDLE, so req_ready=1.
  - rd=we=0, a=0, d=0.
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, wait counter 0.
- Reset asserted mid-operation aborts immediately: strobes drop asynchronously and no response is produced.
- Latencies are counted from the acceptance edge, with a zero-wait bus:
  - Load or full store: rsp_valid in cycle 2.
  - Sub-word store or AMO: rsp_valid in cycle 4.
  - Error response: rsp_valid in cycle 1.
- Each bus wait cycle adds 1 cycle.
- rsp_valid lasts exactly 1 cycle. req_ready returns the cycle after RESP. There are no back-to-back acceptances.
- rsp_rdata/rsp_err are registered and stay stable until the next response.
- ready while rd=we=0 in IDLE, MERGE or RESP is ignored.

## Configuration
- LSU_AMO_EN defined: AMO path and the op ALU are built.
- LSU_AMO_EN undefined: no AMO logic is built. req_amo=1 returns err=3 after 1 cycle with no bus access. req_amoop is unused.

## Test plan
- LW, addr 0x100, spo=0x78563412, ready tied 1 → rd pulse at cycle 1, a=0x100, rsp at cycle 2 with rdata=0x12345678, err=0.
- LB signed at 0x103, memory word 0x80FF0011 (bus-swapped) → rdata=0xFFFFFF80. Same access with LBU → 0x00000080.
- SB 0xAB to 0x101, memory 0x44332211 → read, then write d carrying 0x4433AB11 (swapped), one rd and one we pulse, rsp at cycle 4.
- SH to 0x102 with 3 wait states per beat → address held stable throughout, rsp at cycle 10, final memory word correct.
- LW at 0x102 → err=1 at cycle 1, no rd/we. LW with ready never high, TIMEOUT=8 → err=2, rdata=0 after 8 wait cycles.
- LSU_AMO_EN defined: AMOADD.W at 0x200, memory 5, wdata 7 → memory 12, rdata 5. Undefined: same stimulus → err=3, memory unchanged.
